// File: rtl/floo_sam_cfg_ctrl.sv
// Purpose: SAM rule controller. Software fills a shadow table; COMMIT drains in-flight translations, then copies shadow to active.
// Latency: WRITE lands in shadow at the next edge; with nothing in flight a COMMIT shows the new table 2 cycles after accept.
// Backpressure: cfg_ready_o is low during DRAIN/SWAP; stall_o holds off requesters during a commit or while the in-flight count is full.
module floo_sam_cfg_ctrl #(
    parameter int unsigned NumRules       = 8,
    parameter int unsigned AddrWidth      = 48,
    parameter int unsigned IdWidth        = 8,
    parameter int unsigned MaxOutstanding = 16,
    parameter int unsigned RuleIdxWidth   = (NumRules > 1) ? $clog2(NumRules) : 1,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    input  logic                          cfg_commit_i,
    input  logic [RuleIdxWidth-1:0]       cfg_idx_i,
    input  logic                          cfg_rule_valid_i,
    input  logic [AddrWidth-1:0]          cfg_start_addr_i,
    input  logic [AddrWidth-1:0]          cfg_end_addr_i,
    input  logic [IdWidth-1:0]            cfg_id_i,
    output logic                          cfg_err_o,
    input  logic                          txn_start_i,
    input  logic                          txn_done_i,
    output logic                          stall_o,
    output logic                          config_ongoing_o,
    output logic [NumRules-1:0]           rule_valid_o,
    output logic [NumRules*AddrWidth-1:0] rule_start_o,
    output logic [NumRules*AddrWidth-1:0] rule_end_o,
    output logic [NumRules*IdWidth-1:0]   rule_id_o,
    output logic [7:0]                    epoch_o,
    output logic [CntWidth-1:0]           outstanding_o
);

    // One rule slot: valid bit, [start, end) address window and destination ID.
    typedef struct packed {
        logic                 vld;
        logic [AddrWidth-1:0] start_addr;
        logic [AddrWidth-1:0] end_addr;
        logic [IdWidth-1:0]   id;
    } rule_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } state_e;

    localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MaxOutstanding);
    // When the slot count fills the index space every index is legal.
    localparam bit                  IdxFull = (NumRules == (1 << RuleIdxWidth));

    state_e              r_state;
    state_e              w_state_nxt;
    rule_t               r_shadow [NumRules];
    rule_t               r_active [NumRules];
    logic [CntWidth-1:0] r_cnt;
    logic [7:0]          r_epoch;
    logic                r_cfg_err;

    logic                w_cfg_hs;
    logic                w_wr_hs;
    logic                w_commit_hs;
    logic                w_idx_oob;
    logic                w_range_bad;
    logic                w_wr_reject;
    logic                w_wr_en;
    logic                w_cnt_full;
    logic                w_cnt_empty;
    logic                w_fsm_stall;
    rule_t               w_wr_rule;

    // Command decode: only IDLE accepts commands, so a handshake implies IDLE.
    assign w_cfg_hs    = cfg_valid_i && cfg_ready_o;
    assign w_wr_hs     = w_cfg_hs && !cfg_commit_i;
    assign w_commit_hs = w_cfg_hs && cfg_commit_i;
    assign w_cnt_full  = (r_cnt == MaxCnt);
    assign w_cnt_empty = (r_cnt == '0);

    generate
        if (IdxFull) begin : g_idx_full
            assign w_idx_oob = 1'b0;
        end else begin : g_idx_part
            assign w_idx_oob = (32'(cfg_idx_i) >= NumRules);
        end
    endgenerate

    // Empty or inverted windows are only meaningful to reject for valid rules;
    // an invalid slot may carry any bounds.
    assign w_range_bad = cfg_rule_valid_i && (cfg_start_addr_i >= cfg_end_addr_i);
    assign w_wr_reject = w_wr_hs && (w_idx_oob || w_range_bad);
    assign w_wr_en     = w_wr_hs && !w_idx_oob && !w_range_bad;

    assign w_wr_rule.vld        = cfg_rule_valid_i;
    assign w_wr_rule.start_addr = cfg_start_addr_i;
    assign w_wr_rule.end_addr   = cfg_end_addr_i;
    assign w_wr_rule.id         = cfg_id_i;

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: leave DRAIN only once nothing is in flight and no retire is landing this cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_commit_hs) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_cnt_empty && !txn_done_i) begin
                    w_state_nxt = ST_SWAP;
                end
            end
            ST_SWAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: decoded from state only, so no input reaches these combinationally.
    always_comb begin
        cfg_ready_o      = 1'b0;
        config_ongoing_o = 1'b0;
        w_fsm_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cfg_ready_o = 1'b1;
            end
            ST_DRAIN, ST_SWAP: begin
                config_ongoing_o = 1'b1;
                w_fsm_stall      = 1'b1;
            end
            default: begin
                cfg_ready_o = 1'b0;
            end
        endcase
    end

    // A full in-flight count also stalls, independent of commit state.
    assign stall_o = w_fsm_stall || w_cnt_full;

    // Shadow table: accepted writes land here; reset clears it so an aborted commit leaves nothing behind.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NumRules; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_wr_en) begin
            for (int unsigned i = 0; i < NumRules; i++) begin
                if (cfg_idx_i == RuleIdxWidth'(i)) begin
                    r_shadow[i] <= w_wr_rule;
                end
            end
        end
    end

    // Active table: whole-table copy in the single SWAP cycle, so the decoder never sees a mix.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NumRules; i++) begin
                r_active[i] <= '0;
            end
        end else if (r_state == ST_SWAP) begin
            for (int unsigned i = 0; i < NumRules; i++) begin
                r_active[i] <= r_shadow[i];
            end
        end
    end

    // Epoch counts completed commits and wraps naturally at 8 bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_epoch <= 8'd0;
        end else if (r_state == ST_SWAP) begin
            r_epoch <= r_epoch + 8'd1;
        end
    end

    // In-flight counter: saturates at both ends; simultaneous start and done cancel.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else begin
            case ({txn_start_i, txn_done_i})
                2'b10: begin
                    if (!w_cnt_full) begin
                        r_cnt <= r_cnt + CntWidth'(1);
                    end
                end
                2'b01: begin
                    if (!w_cnt_empty) begin
                        r_cnt <= r_cnt - CntWidth'(1);
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Rejected WRITE produces a single registered error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_wr_reject;
        end
    end

    // Flatten the active table onto the decoder-facing buses.
    always_comb begin
        rule_valid_o = '0;
        rule_start_o = '0;
        rule_end_o   = '0;
        rule_id_o    = '0;
        for (int unsigned i = 0; i < NumRules; i++) begin
            rule_valid_o[i]                          = r_active[i].vld;
            rule_start_o[i*AddrWidth +: AddrWidth]   = r_active[i].start_addr;
            rule_end_o[i*AddrWidth +: AddrWidth]     = r_active[i].end_addr;
            rule_id_o[i*IdWidth +: IdWidth]          = r_active[i].id;
        end
    end

    assign cfg_err_o     = r_cfg_err;
    assign epoch_o       = r_epoch;
    assign outstanding_o = r_cnt;

    // Protocol checks on requester and software behaviour; reported as warnings since the counter tolerates them.
    a_start_at_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(txn_start_i && w_cnt_full))
        else $warning("protocol: txn_start_i with in-flight count at maximum");

    a_done_at_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(txn_done_i && w_cnt_empty))
        else $warning("protocol: txn_done_i with nothing in flight");

    a_start_in_stall: assert property (@(posedge clk_i) disable iff (rst_i)
        !(txn_start_i && stall_o))
        else $warning("protocol: txn_start_i while stall_o is high");

    a_cfg_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (cfg_valid_i && !cfg_ready_o) |=> (cfg_valid_i && $stable(cfg_commit_i) && $stable(cfg_idx_i)
            && $stable(cfg_rule_valid_i) && $stable(cfg_start_addr_i) && $stable(cfg_end_addr_i)
            && $stable(cfg_id_i)))
        else $warning("protocol: config command changed while back-pressured");

endmodule

// File: tb/tb_floo_sam_cfg_ctrl.sv
// Directed bench for floo_sam_cfg_ctrl with NumRules=6 so an out-of-range slot index is encodable.
// Inputs change #1 after the rising edge; outputs are sampled there too, before the next edge.
// Each scenario task checks its own expectations inline.
module tb_floo_sam_cfg_ctrl;

    localparam int NR  = 6;
    localparam int AW  = 48;
    localparam int IW  = 8;
    localparam int MO  = 16;
    localparam int RIW = 3;
    localparam int CW  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              cfg_commit;
    logic [RIW-1:0]    cfg_idx;
    logic              cfg_rule_valid;
    logic [AW-1:0]     cfg_start;
    logic [AW-1:0]     cfg_end;
    logic [IW-1:0]     cfg_id;
    logic              cfg_err;
    logic              txn_start;
    logic              txn_done;
    logic              stall;
    logic              ongoing;
    logic [NR-1:0]     rule_valid;
    logic [NR*AW-1:0]  rule_start;
    logic [NR*AW-1:0]  rule_end;
    logic [NR*IW-1:0]  rule_id;
    logic [7:0]        epoch;
    logic [CW-1:0]     outstanding;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    floo_sam_cfg_ctrl #(
        .NumRules      (NR),
        .AddrWidth     (AW),
        .IdWidth       (IW),
        .MaxOutstanding(MO)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cfg_valid_i     (cfg_valid),
        .cfg_ready_o     (cfg_ready),
        .cfg_commit_i    (cfg_commit),
        .cfg_idx_i       (cfg_idx),
        .cfg_rule_valid_i(cfg_rule_valid),
        .cfg_start_addr_i(cfg_start),
        .cfg_end_addr_i  (cfg_end),
        .cfg_id_i        (cfg_id),
        .cfg_err_o       (cfg_err),
        .txn_start_i     (txn_start),
        .txn_done_i      (txn_done),
        .stall_o         (stall),
        .config_ongoing_o(ongoing),
        .rule_valid_o    (rule_valid),
        .rule_start_o    (rule_start),
        .rule_end_o      (rule_end),
        .rule_id_o       (rule_id),
        .epoch_o         (epoch),
        .outstanding_o   (outstanding)
    );

    function automatic logic [IW-1:0] id_of(input int s);
        return rule_id[s*IW +: IW];
    endfunction

    function automatic logic [AW-1:0] start_of(input int s);
        return rule_start[s*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] end_of(input int s);
        return rule_end[s*AW +: AW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!cfg_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_handshake: cfg_ready_o=%b after %0d cycles, required 1", nm, cfg_ready, n);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (stall && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_commit_done: stall_o=%b after %0d cycles, required 0", nm, stall, n);
        end
    endtask

    task automatic do_write(input logic [RIW-1:0] idx, input logic v, input logic [AW-1:0] s,
                            input logic [AW-1:0] e, input logic [IW-1:0] id);
        cfg_valid      = 1'b1;
        cfg_commit     = 1'b0;
        cfg_idx        = idx;
        cfg_rule_valid = v;
        cfg_start      = s;
        cfg_end        = e;
        cfg_id         = id;
        wait_ready("write");
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_commit();
        cfg_valid  = 1'b1;
        cfg_commit = 1'b1;
        wait_ready("commit");
        tick();
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_idx = '0; cfg_rule_valid = 1'b0;
        cfg_start = '0; cfg_end = '0; cfg_id = '0; txn_start = 1'b0; txn_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (rule_valid !== 6'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", rule_valid); end
        checks++; if (rule_id !== '0) begin errors++; $display("FAIL rst_id: got %h want 0", rule_id); end
        checks++; if (epoch !== 8'd0) begin errors++; $display("FAIL rst_epoch: got %0d want 0", epoch); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", cfg_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
        checks++; if (ongoing !== 1'b0) begin errors++; $display("FAIL rst_ongoing: got %b want 0", ongoing); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", cfg_err); end
        checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", outstanding); end
    endtask

    task automatic test_write_commit();
        int n = 0;
        do_write(3'd2, 1'b1, 48'h1000, 48'h2000, 8'h05);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL wc_err: got %b want 0", cfg_err); end
        checks++; if (rule_valid !== 6'b0) begin errors++; $display("FAIL wc_active_early: got %b want 0", rule_valid); end
        cfg_valid = 1'b1; cfg_commit = 1'b1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wc_stall_pre: got %b want 0", stall); end
        tick();
        cfg_valid = 1'b0; cfg_commit = 1'b0;
        while (stall && n < 10) begin
            checks++; if (rule_valid !== 6'b0) begin errors++; $display("FAIL wc_active_during: got %b want 0", rule_valid); end
            checks++; if (epoch !== 8'd0) begin errors++; $display("FAIL wc_epoch_during: got %0d want 0", epoch); end
            n++;
            tick();
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL wc_stall_cycles: got %0d want 2", n); end
        checks++; if (rule_valid !== 6'b000100) begin errors++; $display("FAIL wc_valid: got %b want 000100", rule_valid); end
        checks++; if (id_of(2) !== 8'h05) begin errors++; $display("FAIL wc_id2: got %h want 05", id_of(2)); end
        checks++; if (start_of(2) !== 48'h1000) begin errors++; $display("FAIL wc_start2: got %h want 1000", start_of(2)); end
        checks++; if (end_of(2) !== 48'h2000) begin errors++; $display("FAIL wc_end2: got %h want 2000", end_of(2)); end
        checks++; if (epoch !== 8'd1) begin errors++; $display("FAIL wc_epoch: got %0d want 1", epoch); end
        checks++; if (ongoing !== 1'b0) begin errors++; $display("FAIL wc_ongoing: got %b want 0", ongoing); end
    endtask

    task automatic test_drain();
        txn_start = 1'b1;
        tick(); tick(); tick();
        txn_start = 1'b0;
        checks++; if (outstanding !== 5'd3) begin errors++; $display("FAIL dr_cnt3: got %0d want 3", outstanding); end
        cfg_valid = 1'b1; cfg_commit = 1'b1;
        tick();
        cfg_valid = 1'b0; cfg_commit = 1'b0;
        // Retires in cycles 4, 6, 9 after accept; count hits 0 at cycle 10, SWAP in 11, idle at 12.
        for (int c = 0; c <= 12; c++) begin
            txn_done = (c == 4 || c == 6 || c == 9);
            checks++; if (stall !== (c <= 11)) begin errors++; $display("FAIL dr_stall_c%0d: got %b want %b", c, stall, (c <= 11)); end
            checks++; if (ongoing !== (c <= 11)) begin errors++; $display("FAIL dr_ongoing_c%0d: got %b want %b", c, ongoing, (c <= 11)); end
            checks++; if (epoch !== ((c <= 11) ? 8'd1 : 8'd2)) begin errors++; $display("FAIL dr_epoch_c%0d: got %0d want %0d", c, epoch, (c <= 11) ? 1 : 2); end
            if (c == 5) begin
                checks++; if (outstanding !== 5'd2) begin errors++; $display("FAIL dr_cnt_c5: got %0d want 2", outstanding); end
            end
            if (c == 10) begin
                checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL dr_cnt_c10: got %0d want 0", outstanding); end
            end
            tick();
        end
        txn_done = 1'b0;
        checks++; if (epoch !== 8'd2) begin errors++; $display("FAIL dr_epoch_end: got %0d want 2", epoch); end
        checks++; if (rule_valid !== 6'b000100) begin errors++; $display("FAIL dr_valid: got %b want 000100", rule_valid); end
    endtask

    task automatic test_errors();
        do_write(3'd6, 1'b1, 48'h100, 48'h200, 8'h77);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL er_oob_pulse: got %b want 1", cfg_err); end
        tick();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL er_oob_clear: got %b want 0", cfg_err); end
        do_write(3'd3, 1'b1, 48'h3000, 48'h3000, 8'h33);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL er_range_pulse: got %b want 1", cfg_err); end
        tick();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL er_range_clear: got %b want 0", cfg_err); end
        do_write(3'd4, 1'b0, 48'h3000, 48'h3000, 8'h44);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL er_inv_pulse: got %b want 0", cfg_err); end
        tick();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL er_inv_clear: got %b want 0", cfg_err); end
        do_commit();
        wait_idle("errors");
        checks++; if (rule_valid !== 6'b000100) begin errors++; $display("FAIL er_valid: got %b want 000100", rule_valid); end
        checks++; if (rule_id !== 48'h00_44_00_05_00_00) begin errors++; $display("FAIL er_ids: got %h want 004400050000", rule_id); end
        checks++; if (start_of(4) !== 48'h3000) begin errors++; $display("FAIL er_start4: got %h want 3000", start_of(4)); end
        checks++; if (start_of(3) !== 48'h0) begin errors++; $display("FAIL er_start3: got %h want 0", start_of(3)); end
        checks++; if (epoch !== 8'd3) begin errors++; $display("FAIL er_epoch: got %0d want 3", epoch); end
    endtask

    task automatic test_back_to_back();
        cfg_valid = 1'b1; cfg_commit = 1'b0;
        cfg_idx = 3'd0; cfg_rule_valid = 1'b1; cfg_start = 48'h0; cfg_end = 48'h800; cfg_id = 8'h10;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL bb_ready0: got %b want 1", cfg_ready); end
        tick();
        cfg_idx = 3'd1; cfg_start = 48'h800; cfg_end = 48'h1000; cfg_id = 8'h11;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL bb_ready1: got %b want 1", cfg_ready); end
        tick();
        cfg_commit = 1'b1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL bb_ready2: got %b want 1", cfg_ready); end
        tick();
        cfg_valid = 1'b0; cfg_commit = 1'b0;
        wait_idle("b2b");
        checks++; if (rule_valid !== 6'b000111) begin errors++; $display("FAIL bb_valid: got %b want 000111", rule_valid); end
        checks++; if (id_of(0) !== 8'h10) begin errors++; $display("FAIL bb_id0: got %h want 10", id_of(0)); end
        checks++; if (id_of(1) !== 8'h11) begin errors++; $display("FAIL bb_id1: got %h want 11", id_of(1)); end
        checks++; if (end_of(0) !== 48'h800) begin errors++; $display("FAIL bb_end0: got %h want 800", end_of(0)); end
        checks++; if (epoch !== 8'd4) begin errors++; $display("FAIL bb_epoch: got %0d want 4", epoch); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        txn_start = 1'b1;
        tick();
        txn_start = 1'b0;
        do_commit();
        cfg_valid = 1'b1; cfg_commit = 1'b0;
        cfg_idx = 3'd5; cfg_rule_valid = 1'b1; cfg_start = 48'h5000; cfg_end = 48'h6000; cfg_id = 8'h55;
        for (int c = 0; c < 3; c++) begin
            checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c%0d: got %b want 0", c, cfg_ready); end
            tick();
        end
        txn_done = 1'b1;
        tick();
        txn_done = 1'b0;
        // Count now 0: one DRAIN cycle, one SWAP cycle, then ready.
        while (!cfg_ready && n < 20) begin
            tick();
            n++;
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL bp_wait: got %0d cycles want 2", n); end
        tick();
        cfg_valid = 1'b0;
        checks++; if (rule_valid[5] !== 1'b0) begin errors++; $display("FAIL bp_not_active: got %b want 0", rule_valid[5]); end
        checks++; if (epoch !== 8'd5) begin errors++; $display("FAIL bp_epoch1: got %0d want 5", epoch); end
        do_commit();
        wait_idle("bp");
        checks++; if (rule_valid !== 6'b100111) begin errors++; $display("FAIL bp_valid: got %b want 100111", rule_valid); end
        checks++; if (id_of(5) !== 8'h55) begin errors++; $display("FAIL bp_id5: got %h want 55", id_of(5)); end
        checks++; if (epoch !== 8'd6) begin errors++; $display("FAIL bp_epoch2: got %0d want 6", epoch); end
    endtask

    task automatic test_saturation();
        txn_start = 1'b1;
        for (int i = 0; i < MO; i++) tick();
        txn_start = 1'b0;
        checks++; if (outstanding !== 5'd16) begin errors++; $display("FAIL sat_cnt: got %0d want 16", outstanding); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall: got %b want 1", stall); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL sat_ready: got %b want 1", cfg_ready); end
        checks++; if (ongoing !== 1'b0) begin errors++; $display("FAIL sat_ongoing: got %b want 0", ongoing); end
        txn_start = 1'b1;
        tick();
        txn_start = 1'b0;
        checks++; if (outstanding !== 5'd16) begin errors++; $display("FAIL sat_extra: got %0d want 16", outstanding); end
        txn_start = 1'b1; txn_done = 1'b1;
        tick();
        txn_start = 1'b0;
        checks++; if (outstanding !== 5'd16) begin errors++; $display("FAIL sat_both: got %0d want 16", outstanding); end
        tick();
        checks++; if (outstanding !== 5'd15) begin errors++; $display("FAIL sat_dec: got %0d want 15", outstanding); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sat_unstall: got %b want 0", stall); end
        for (int i = 0; i < 15; i++) tick();
        txn_done = 1'b0;
        checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL sat_empty: got %0d want 0", outstanding); end
    endtask

    task automatic test_reset_mid_drain();
        txn_start = 1'b1;
        tick(); tick();
        txn_start = 1'b0;
        do_commit();
        tick();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rm_stall_pre: got %b want 1", stall); end
        checks++; if (outstanding !== 5'd2) begin errors++; $display("FAIL rm_cnt_pre: got %0d want 2", outstanding); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b want 1", cfg_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rm_stall: got %b want 0", stall); end
        checks++; if (ongoing !== 1'b0) begin errors++; $display("FAIL rm_ongoing: got %b want 0", ongoing); end
        checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL rm_cnt: got %0d want 0", outstanding); end
        checks++; if (epoch !== 8'd0) begin errors++; $display("FAIL rm_epoch: got %0d want 0", epoch); end
        checks++; if (rule_valid !== 6'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", rule_valid); end
        checks++; if (rule_start !== '0) begin errors++; $display("FAIL rm_start: got %h want 0", rule_start); end
        do_commit();
        wait_idle("rm");
        checks++; if (rule_valid !== 6'b0) begin errors++; $display("FAIL rm_valid_after: got %b want 0", rule_valid); end
        checks++; if (rule_id !== '0) begin errors++; $display("FAIL rm_id_after: got %h want 0", rule_id); end
        checks++; if (rule_end !== '0) begin errors++; $display("FAIL rm_end_after: got %h want 0", rule_end); end
        checks++; if (epoch !== 8'd1) begin errors++; $display("FAIL rm_epoch_after: got %0d want 1", epoch); end
    endtask

    initial begin
        test_reset();
        test_write_commit();
        test_drain();
        test_errors();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
